mano_control_unit: RTL and testbench

Control sequencer for the 8-bit Mano-style datapath. It fetches and decodes instructions and drives every datapath strobe: ALU function selects (AND/ADD/LDA/COM), register loads, bus source select, E-flag control and a req/ack memory handshake. It is the producer of the select lines consumed by the ALU and sits between the instruction register, memory and the register file.

---
 rtl/mano_pkg.sv | 40 ++++
 rtl/mano_opdecode.sv | 44 ++++
 rtl/mano_control_unit.sv | 156 +++++++++++++++
 tb/tb_mano_control_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mano_pkg.sv
// Shared types and constants for the Mano-style control sequencer.
// Holds the state enum, opcodes, bus source codes and register-reference bit positions.
package mano_pkg;

  typedef enum logic [2:0] {
    FETCH0,
    FETCH1,
    DECODE,
    INDIRECT,
    EXEC0,
    EXEC1,
    REG,
    HALT
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_LDA = 3'b010;
  localparam logic [2:0] OP_STA = 3'b011;
  localparam logic [2:0] OP_BUN = 3'b100;
  localparam logic [2:0] OP_REG = 3'b111;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  localparam int REG_CLA = 3;
  localparam int REG_CMA = 2;
  localparam int REG_CME = 1;
  localparam int REG_HLT = 0;

  function automatic logic [2:0] tCountNext(input logic [2:0] cur);
    return (cur == 3'd7) ? 3'd7 : cur + 3'd1;
  endfunction

endpackage

// File: rtl/mano_opdecode.sv
// Combinational instruction classifier: maps the I bit and opcode to one-hot class flags.
module mano_opdecode
  import mano_pkg::*;
(
  input  logic [3:0] i_opField,
  output logic       o_isAnd,
  output logic       o_isAdd,
  output logic       o_isLda,
  output logic       o_isSta,
  output logic       o_isBun,
  output logic       o_isReg,
  output logic       o_isNop
);

  logic       w_indirect;
  logic [2:0] w_opcode;

  assign w_indirect = i_opField[3];
  assign w_opcode   = i_opField[2:0];

  always_comb begin
    o_isAnd = 1'b0;
    o_isAdd = 1'b0;
    o_isLda = 1'b0;
    o_isSta = 1'b0;
    o_isBun = 1'b0;
    o_isReg = 1'b0;
    o_isNop = 1'b0;
    case (w_opcode)
      OP_AND:  o_isAnd = 1'b1;
      OP_ADD:  o_isAdd = 1'b1;
      OP_LDA:  o_isLda = 1'b1;
      OP_STA:  o_isSta = 1'b1;
      OP_BUN:  o_isBun = 1'b1;
      // Opcode 111 is only register-reference when the I bit is clear.
      OP_REG: begin
        if (!w_indirect) o_isReg = 1'b1;
        else             o_isNop = 1'b1;
      end
      default: o_isNop = 1'b1;
    endcase
  end

endmodule

// File: rtl/mano_control_unit.sv
// Fetch/decode/execute sequencer driving every datapath strobe of the 8-bit Mano machine.
// Outputs decode from the registered state plus ir; ack-gated strobes fire only in the ack cycle.
module mano_control_unit
  import mano_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ir,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic [2:0] bus_sel,
  output logic       ar_ld,
  output logic       pc_ld,
  output logic       pc_inc,
  output logic       ir_ld,
  output logic       dr_ld,
  output logic       ac_ld,
  output logic       alu_and,
  output logic       alu_add,
  output logic       alu_lda,
  output logic       alu_com,
  output logic       e_ld,
  output logic       e_clr,
  output logic       e_com,
  output logic       halted,
  output logic [2:0] t_count
);

  state_t     r_state;
  state_t     w_nextState;
  logic [2:0] r_tCount;
  logic       w_isAnd, w_isAdd, w_isLda, w_isSta, w_isBun, w_isReg, w_isNop;

  mano_opdecode u_opdecode (
    .i_opField (ir[7:4]),
    .o_isAnd   (w_isAnd),
    .o_isAdd   (w_isAdd),
    .o_isLda   (w_isLda),
    .o_isSta   (w_isSta),
    .o_isBun   (w_isBun),
    .o_isReg   (w_isReg),
    .o_isNop   (w_isNop)
  );

  // mem_ack is only consulted in states that hold mem_req high.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      FETCH0:   w_nextState = FETCH1;
      FETCH1:   if (mem_ack) w_nextState = DECODE;
      DECODE: begin
        if (w_isNop)      w_nextState = FETCH0;
        else if (w_isReg) w_nextState = REG;
        else if (ir[7])   w_nextState = INDIRECT;
        else              w_nextState = EXEC0;
      end
      INDIRECT: if (mem_ack) w_nextState = EXEC0;
      EXEC0: begin
        if (w_isBun)      w_nextState = FETCH0;
        else if (mem_ack) w_nextState = w_isSta ? FETCH0 : EXEC1;
      end
      EXEC1:    w_nextState = FETCH0;
      REG:      w_nextState = ir[REG_HLT] ? HALT : FETCH0;
      HALT:     w_nextState = HALT;
      default:  w_nextState = FETCH0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= FETCH0;
      r_tCount <= 3'd0;
    end else begin
      r_state <= w_nextState;
      if (w_nextState == FETCH0)       r_tCount <= 3'd0;
      else if (w_nextState != r_state) r_tCount <= tCountNext(r_tCount);
    end
  end

  // Reset gates every output low combinationally so a mid-wait reset never leaks a load strobe.
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    bus_sel = BUS_NONE;
    ar_ld   = 1'b0;
    pc_ld   = 1'b0;
    pc_inc  = 1'b0;
    ir_ld   = 1'b0;
    dr_ld   = 1'b0;
    ac_ld   = 1'b0;
    alu_and = 1'b0;
    alu_add = 1'b0;
    alu_lda = 1'b0;
    alu_com = 1'b0;
    e_ld    = 1'b0;
    e_clr   = 1'b0;
    e_com   = 1'b0;
    halted  = 1'b0;
    t_count = 3'd0;
    if (rst_n) begin
      t_count = r_tCount;
      case (r_state)
        FETCH0: begin
          bus_sel = BUS_PC;
          ar_ld   = 1'b1;
        end
        FETCH1: begin
          mem_req = 1'b1;
          bus_sel = BUS_MEM;
          ir_ld   = mem_ack;
          pc_inc  = mem_ack;
        end
        DECODE: begin
          bus_sel = BUS_IR;
          ar_ld   = 1'b1;
        end
        INDIRECT: begin
          mem_req = 1'b1;
          bus_sel = BUS_MEM;
          ar_ld   = mem_ack;
        end
        EXEC0: begin
          if (w_isBun) begin
            bus_sel = BUS_AR;
            pc_ld   = 1'b1;
          end else if (w_isSta) begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            bus_sel = BUS_AC;
          end else begin
            mem_req = 1'b1;
            bus_sel = BUS_MEM;
            dr_ld   = mem_ack;
          end
        end
        EXEC1: begin
          alu_and = w_isAnd;
          alu_add = w_isAdd;
          alu_lda = w_isLda;
          e_ld    = w_isAdd;
          ac_ld   = 1'b1;
        end
        // CLA loads AC with no ALU select (zero result) and so wins over CMA.
        REG: begin
          ac_ld   = ir[REG_CLA] | ir[REG_CMA];
          alu_com = ir[REG_CMA] & ~ir[REG_CLA];
          e_com   = ir[REG_CME];
        end
        HALT:    halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mano_control_unit.sv
// Self-checking bench: a phase-list model expands each instruction into per-cycle stimulus
// and expected outputs, which a negedge compare process checks against the DUT.
module tb_mano_control_unit;

  typedef struct packed {
    logic       memReq;
    logic       memWe;
    logic [2:0] busSel;
    logic       arLd;
    logic       pcLd;
    logic       pcInc;
    logic       irLd;
    logic       drLd;
    logic       acLd;
    logic       aluAnd;
    logic       aluAdd;
    logic       aluLda;
    logic       aluCom;
    logic       eLd;
    logic       eClr;
    logic       eCom;
    logic       halted;
    logic [2:0] tCount;
  } outVec_t;

  typedef struct packed {
    logic       rstN;
    logic [7:0] ir;
    logic       ack;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ir;
  logic       mem_ack;
  logic       mem_req, mem_we;
  logic [2:0] bus_sel;
  logic       ar_ld, pc_ld, pc_inc, ir_ld, dr_ld, ac_ld;
  logic       alu_and, alu_add, alu_lda, alu_com;
  logic       e_ld, e_clr, e_com, halted;
  logic [2:0] t_count;

  stim_t   stimQ[$];
  outVec_t expQ[$];
  string   lblQ[$];
  int      curIdx = -1;
  int      checks = 0;
  int      failures = 0;
  outVec_t act;

  always #5 clk = ~clk;

  mano_control_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ir      (ir),
    .mem_ack (mem_ack),
    .mem_req (mem_req),
    .mem_we  (mem_we),
    .bus_sel (bus_sel),
    .ar_ld   (ar_ld),
    .pc_ld   (pc_ld),
    .pc_inc  (pc_inc),
    .ir_ld   (ir_ld),
    .dr_ld   (dr_ld),
    .ac_ld   (ac_ld),
    .alu_and (alu_and),
    .alu_add (alu_add),
    .alu_lda (alu_lda),
    .alu_com (alu_com),
    .e_ld    (e_ld),
    .e_clr   (e_clr),
    .e_com   (e_com),
    .halted  (halted),
    .t_count (t_count)
  );

  assign act = {mem_req, mem_we, bus_sel, ar_ld, pc_ld, pc_inc, ir_ld, dr_ld, ac_ld,
                alu_and, alu_add, alu_lda, alu_com, e_ld, e_clr, e_com, halted, t_count};

  task automatic pushEntry(input string lbl, input logic rstN, input logic [7:0] irv,
                           input logic ack, input outVec_t e);
    stim_t s;
    s.rstN = rstN;
    s.ir   = irv;
    s.ack  = ack;
    stimQ.push_back(s);
    expQ.push_back(e);
    lblQ.push_back(lbl);
  endtask

  // One instruction phase; an access phase spends `waits` cycles before its ack cycle.
  task automatic addPhase(input string name, input logic [7:0] irv, input int ph,
                          input outVec_t base, input outVec_t ackExtra, input bit isAccess,
                          input int waits, input logic noiseAck);
    outVec_t v;
    string   lbl;
    v = base;
    v.tCount = (ph > 7) ? 3'd7 : 3'(ph);
    lbl = $sformatf("%s.t%0d", name, ph);
    if (!isAccess) begin
      pushEntry(lbl, 1'b1, irv, noiseAck, v);
    end else begin
      for (int w = 0; w < waits; w++) pushEntry(lbl, 1'b1, irv, 1'b0, v);
      pushEntry(lbl, 1'b1, irv, 1'b1, v | ackExtra);
    end
  endtask

  task automatic modelInstr(input string name, input logic [7:0] irv, input int waits,
                            input logic noiseAck, input int haltCycles);
    outVec_t    b, a;
    int         ph;
    logic [2:0] opc;
    logic       ind;
    ph  = 0;
    opc = irv[6:4];
    ind = irv[7];
    b = '0; b.busSel = 3'd2; b.arLd = 1'b1;
    addPhase(name, irv, ph, b, '0, 1'b0, 0, noiseAck); ph++;
    b = '0; b.memReq = 1'b1; b.busSel = 3'd7;
    a = '0; a.irLd = 1'b1; a.pcInc = 1'b1;
    addPhase(name, irv, ph, b, a, 1'b1, waits, noiseAck); ph++;
    b = '0; b.busSel = 3'd5; b.arLd = 1'b1;
    addPhase(name, irv, ph, b, '0, 1'b0, 0, noiseAck); ph++;
    if (opc <= 3'd4) begin
      if (ind) begin
        b = '0; b.memReq = 1'b1; b.busSel = 3'd7;
        a = '0; a.arLd = 1'b1;
        addPhase(name, irv, ph, b, a, 1'b1, waits, noiseAck); ph++;
      end
      if (opc <= 3'd2) begin
        b = '0; b.memReq = 1'b1; b.busSel = 3'd7;
        a = '0; a.drLd = 1'b1;
        addPhase(name, irv, ph, b, a, 1'b1, waits, noiseAck); ph++;
        b = '0; b.acLd = 1'b1;
        b.aluAnd = (opc == 3'd0);
        b.aluAdd = (opc == 3'd1);
        b.eLd    = (opc == 3'd1);
        b.aluLda = (opc == 3'd2);
        addPhase(name, irv, ph, b, '0, 1'b0, 0, noiseAck); ph++;
      end else if (opc == 3'd3) begin
        b = '0; b.memReq = 1'b1; b.memWe = 1'b1; b.busSel = 3'd4;
        addPhase(name, irv, ph, b, '0, 1'b1, waits, noiseAck); ph++;
      end else begin
        b = '0; b.busSel = 3'd1; b.pcLd = 1'b1;
        addPhase(name, irv, ph, b, '0, 1'b0, 0, noiseAck); ph++;
      end
    end else if (opc == 3'd7 && !ind) begin
      b = '0;
      b.acLd   = irv[3] | irv[2];
      b.aluCom = irv[2] & ~irv[3];
      b.eCom   = irv[1];
      addPhase(name, irv, ph, b, '0, 1'b0, 0, noiseAck); ph++;
      if (irv[0]) begin
        b = '0; b.halted = 1'b1;
        for (int h = 0; h < haltCycles; h++)
          addPhase(name, irv, ph, b, '0, 1'b0, 0, noiseAck);
      end
    end
  endtask

  task automatic pinModel(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s: model gives %0d, hand value %0d", name, got, want);
    end
  endtask

  task automatic pinVec(input string name, input outVec_t got, input outVec_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: model gives %h, hand value %h", name, got, want);
    end
  endtask

  task automatic buildModel();
    int s;
    int ldaCount;
    pushEntry("reset", 1'b0, 8'h00, 1'b1, '0);
    pushEntry("reset", 1'b0, 8'h00, 1'b1, '0);

    s = expQ.size();
    modelInstr("ADD15", 8'h15, 0, 1'b0, 0);
    pinModel("ADD15.len", expQ.size() - s, 5);
    pinVec("ADD15.first", expQ[s], 22'h050000);
    pinVec("ADD15.c5", expQ[s + 4], 22'h000A44);

    s = expQ.size();
    modelInstr("LDAA3", 8'hA3, 2, 1'b0, 0);
    pinModel("LDAA3.len", expQ.size() - s, 12);
    ldaCount = 0;
    for (int k = s; k < expQ.size(); k++) if (expQ[k].aluLda) ldaCount++;
    pinModel("LDAA3.ldaOnce", ldaCount, 1);

    s = expQ.size();
    modelInstr("STA32", 8'h32, 0, 1'b0, 0);
    pinModel("STA32.len", expQ.size() - s, 4);
    s = expQ.size();
    modelInstr("BUN47", 8'h47, 0, 1'b1, 0);
    pinModel("BUN47.len", expQ.size() - s, 4);
    pinVec("BUN47.c4", expQ[s + 3], 22'h028003);

    s = expQ.size();
    modelInstr("CMA74", 8'h74, 0, 1'b0, 0);
    pinModel("CMA74.len", expQ.size() - s, 4);
    s = expQ.size();
    modelInstr("CLA7C", 8'h7C, 0, 1'b0, 0);
    pinVec("CLA7C.c4", expQ[s + 3], 22'h000803);
    modelInstr("CME72", 8'h72, 0, 1'b1, 0);

    s = expQ.size();
    modelInstr("NOP50", 8'h50, 0, 1'b1, 0);
    pinModel("NOP50.len", expQ.size() - s, 3);
    modelInstr("NOPF0", 8'hF0, 0, 1'b0, 0);

    s = expQ.size();
    modelInstr("ADD95", 8'h95, 1, 1'b0, 0);
    pinModel("ADD95.len", expQ.size() - s, 9);
    modelInstr("AND0A", 8'h0A, 1, 1'b1, 0);
    modelInstr("STAB6", 8'hB6, 1, 1'b0, 0);
    modelInstr("BUNC1", 8'hC1, 0, 1'b0, 0);

    s = expQ.size();
    modelInstr("HLT71", 8'h71, 0, 1'b1, 20);
    pinModel("HLT71.len", expQ.size() - s, 24);

    pushEntry("resetHalt", 1'b0, 8'h71, 1'b0, '0);
    modelInstr("LDA20", 8'h20, 0, 1'b0, 0);

    pushEntry("midWait.t0", 1'b1, 8'h20, 1'b0, 22'h050000);
    pushEntry("midWait.t1", 1'b1, 8'h20, 1'b0, 22'h2E0001);
    pushEntry("midWait.t1", 1'b1, 8'h20, 1'b0, 22'h2E0001);
    pushEntry("midWait.rst", 1'b0, 8'h20, 1'b1, '0);
    modelInstr("STA35", 8'h35, 1, 1'b0, 0);
  endtask

  task automatic applyStimulus(input int k);
    rst_n   = stimQ[k].rstN;
    ir      = stimQ[k].ir;
    mem_ack = stimQ[k].ack;
    curIdx  = k;
  endtask

  task automatic checkOutput(input int k);
    checks++;
    if (act !== expQ[k]) begin
      failures++;
      $display("[TB] FAIL %s (cycle %0d): got %h expected %h", lblQ[k], k, act, expQ[k]);
    end
  endtask

  always @(negedge clk) begin
    if (curIdx >= 0) checkOutput(curIdx);
  end

  initial begin
    rst_n   = 1'b0;
    ir      = 8'h00;
    mem_ack = 1'b0;
    buildModel();
    $display("[TB] running %0d cycles", expQ.size());
    for (int k = 0; k < expQ.size(); k++) begin
      @(posedge clk);
      #1;
      applyStimulus(k);
    end
    @(posedge clk);
    #1;
    curIdx = -1;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
